// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 MEM-stage load/store path: funct3 access
// encodings, load/store FSM state encoding and the misalignment rule.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // funct3[1:0]: 00 byte, 01 half, anything else is a word access.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        logic half_acc;
        logic word_acc;
        half_acc = (funct3[1:0] == 2'b01);
        word_acc = funct3[1];
        return (half_acc && addr[0]) || (word_acc && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: selects the byte/half lane from a memory
// word and sign- or zero-extends it. Undefined funct3 values return the word.
module load_formatter
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
    assign half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   result_o = {{16{half_lane[15]}}, half_lane};
            F3_LBU:  result_o = {24'h000000, byte_lane};
            F3_LHU:  result_o = {16'h0000, half_lane};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one word-aligned memory request per
// instruction and stalls the pipeline until it completes. Optional feature
// macro: MEM_ACCESS_MISALIGN_TRAP_EN (adds misalign_fault output).
module mem_access_unit
    import rv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    output logic [31:0] load_data_out,
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    output logic        misalign_fault,
`endif
    output logic [1:0]  dbg_state,
    output logic        busywait
);

    // Handshake: mem_rd/mem_wr act as request-valid and stay asserted with
    // address/data/byteen stable until the memory answers with mem_ready=1;
    // the request is retired on the edge where both are high.
    state_t      state_q, state_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [31:0] load_q, load_d;
    logic [31:0] fmt_data;
    logic        req;
    logic        misalign;

    assign req = mem_read_in | mem_write_in;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    assign misalign       = is_misaligned(funct3_in, addr_in[1:0]);
    assign misalign_fault = fault_q;
`else
    assign misalign = 1'b0;
`endif

    load_formatter u_fmt (
        .rdata_i  (mem_rdata),
        .addr_i   (addr_in[1:0]),
        .funct3_i (funct3_in),
        .result_o (fmt_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            byteen_q <= 4'h0;
            load_q   <= 32'h0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            byteen_q <= byteen_d;
            load_q   <= load_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            fault_q  <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req) state_d = misalign ? ST_DONE : ST_ACCESS;
            ST_ACCESS: if (mem_ready) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busywait = ((state_q == ST_IDLE) && req) || (state_q == ST_ACCESS);
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        byteen_d = byteen_q;
        load_d   = load_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        fault_d  = (state_q == ST_IDLE) && (state_d == ST_DONE);
`endif
        if ((state_q == ST_IDLE) && (state_d == ST_ACCESS)) begin
            mem_rd_d = mem_read_in & ~mem_write_in;
            mem_wr_d = mem_write_in;
            addr_d   = {addr_in[31:2], 2'b00};
            byteen_d = 4'b1111;
            if (mem_write_in) begin
                case (funct3_in[1:0])
                    2'b00: begin
                        wdata_d  = {4{store_data_in[7:0]}};
                        byteen_d = 4'b0001 << addr_in[1:0];
                    end
                    2'b01: begin
                        wdata_d  = {2{store_data_in[15:0]}};
                        byteen_d = 4'b0011 << {addr_in[1], 1'b0};
                    end
                    default: wdata_d = store_data_in;
                endcase
            end
        end
        if ((state_q == ST_ACCESS) && !mem_ready) begin
            mem_rd_d = mem_rd_q;
            mem_wr_d = mem_wr_q;
        end
        if ((state_q == ST_ACCESS) && mem_ready && mem_rd_q) begin
            load_d = fmt_data;
        end
    end

    assign mem_rd        = mem_rd_q;
    assign mem_wr        = mem_wr_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_byteen    = byteen_q;
    assign load_data_out = load_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed load/store tables, reset
// and back-to-back sequences, and randomized accesses against a lane model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_in, mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in, store_data_in;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, load_data_out;
    logic [3:0]  mem_byteen;
    logic [1:0]  dbg_state;
    logic        busywait;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    mem_access_unit dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .funct3_in     (funct3_in),
        .addr_in       (addr_in),
        .store_data_in (store_data_in),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_byteen    (mem_byteen),
        .load_data_out (load_data_out),
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        .misalign_fault(misalign_fault),
`endif
        .dbg_state     (dbg_state),
        .busywait      (busywait)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_load = 32'h0;
    logic [31:0] busy_hist;
    int          rd_cycles, wr_cycles;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } st_vec_t;

    ld_vec_t ld_tab[10];
    st_vec_t st_tab[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fmt_model(input logic [31:0] w, input logic [31:0] a,
                                              input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b + 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32768) ? (h + 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] be_model(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (!wr) return 4'd15;
        case (f3 % 4)
            0:       return 4'(1 << (a % 4));
            1:       return 4'(3 << (2 * ((a / 2) % 2)));
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] wd_model(input logic [2:0] f3, input logic [31:0] sd);
        case (f3 % 4)
            0:       return (sd & 32'hFF) * 32'h01010101;
            1:       return (sd & 32'hFFFF) * 32'h00010001;
            default: return sd;
        endcase
    endfunction

    function automatic bit fault_model(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if (f3 % 4 == 0) return 1'b0;
        if (f3 % 4 == 1) return (a % 2) != 0;
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic sample();
        busy_hist = {busy_hist[30:0], busywait};
        if (mem_rd) rd_cycles++;
        if (mem_wr) wr_cycles++;
    endtask

    // One complete instruction: IDLE (request seen), ACCESS with 'waits' not-ready
    // cycles, then DONE. Inputs stay held through DONE as the frozen pipeline would.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sd,
                             input int waits, input logic [31:0] rdata);
        logic        is_load;
        bit          flt;
        logic [31:0] eload;
        is_load = rd & ~wr;
        flt     = fault_model(f3, addr);
        exp_q.push_back((is_load && !flt) ? fmt_model(rdata, addr, f3) : last_load);

        @(negedge clk);
        mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
        addr_in = addr; store_data_in = sd;
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        #1;
        sample();
        chk("idle_busy", busywait, 1);
        chk("idle_strobe", {mem_rd, mem_wr}, 0);
        chk("idle_state", dbg_state, 0);

        if (!flt) begin
            for (int i = 0; i <= waits; i++) begin
                @(negedge clk);
                mem_ready = (i == waits);
                mem_rdata = (i == waits) ? rdata : $urandom;
                #1;
                sample();
                chk("acc_busy", busywait, 1);
                chk("acc_state", dbg_state, 1);
                chk("acc_rd", mem_rd, is_load);
                chk("acc_wr", mem_wr, wr);
                chk("acc_addr", mem_addr, {addr[31:2], 2'b00});
                chk("acc_be", mem_byteen, be_model(wr, f3, addr));
                if (wr) chk("acc_wdata", mem_wdata, wd_model(f3, sd));
                obs_addr = mem_addr; obs_be = mem_byteen; obs_wdata = mem_wdata;
            end
        end

        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        #1;
        sample();
        eload = exp_q.pop_front();
        chk("done_busy", busywait, 0);
        chk("done_state", dbg_state, 2);
        chk("done_strobe", {mem_rd, mem_wr}, 0);
        chk("done_load", load_data_out, eload);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        chk("done_fault", misalign_fault, flt);
`endif
        last_load = eload;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        mem_read_in = 1'b0; mem_write_in = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("gap_busy", busywait, 0);
        chk("gap_strobe", {mem_rd, mem_wr}, 0);
    endtask

    initial begin
        ld_tab[0] = '{3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF};
        ld_tab[1] = '{3'b000, 32'h103, 32'h80FF0011, 32'hFFFFFF80};
        ld_tab[2] = '{3'b100, 32'h103, 32'h80FF0011, 32'h00000080};
        ld_tab[3] = '{3'b101, 32'h102, 32'h80FF0011, 32'h000080FF};
        ld_tab[4] = '{3'b001, 32'h102, 32'h80FF0011, 32'hFFFF80FF};
        ld_tab[5] = '{3'b000, 32'h100, 32'h80FF0011, 32'h00000011};
        ld_tab[6] = '{3'b001, 32'h100, 32'h80FF8011, 32'hFFFF8011};
        ld_tab[7] = '{3'b100, 32'h101, 32'h80FF0011, 32'h00000000};
        ld_tab[8] = '{3'b000, 32'h102, 32'h80FF0011, 32'hFFFFFFFF};
        ld_tab[9] = '{3'b011, 32'h104, 32'h13579BDF, 32'h13579BDF};
        st_tab[0] = '{3'b001, 32'h06,  32'h1234ABCD, 32'h04,  4'b1100, 32'hABCDABCD};
        st_tab[1] = '{3'b000, 32'h101, 32'hCAFE0055, 32'h100, 4'b0010, 32'h55555555};
        st_tab[2] = '{3'b010, 32'h200, 32'h89ABCDEF, 32'h200, 4'b1111, 32'h89ABCDEF};
        st_tab[3] = '{3'b001, 32'h300, 32'h0000BEEF, 32'h300, 4'b0011, 32'hBEEFBEEF};

        rst = 1'b1;
        mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'b010;
        addr_in = 32'h0; store_data_in = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_strobe", {mem_rd, mem_wr}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", mem_byteen, 0);
        chk("rst_load", load_data_out, 0);
        chk("rst_busy", busywait, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset abandoned mid-ACCESS
        @(negedge clk);
        mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h100;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("mid_rd_before", mem_rd, 1);
        rst = 1'b1; mem_read_in = 1'b0;
        #1;
        chk("mid_rd_after", mem_rd, 0);
        chk("mid_busy", busywait, 0);
        chk("mid_load", load_data_out, 0);
        chk("mid_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        // LW with two wait states: busywait high exactly four cycles
        busy_hist = 0; rd_cycles = 0; wr_cycles = 0;
        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
        chk("lw_wait_busy", busy_hist[4:0], 5'b11110);
        chk("lw_wait_load", load_data_out, 32'hDEADBEEF);
        chk("lw_wait_rdcyc", rd_cycles, 3);
        idle_cycle();

        for (int i = 0; i < 10; i++) begin
            do_access(1'b1, 1'b0, ld_tab[i].f3, ld_tab[i].addr, 32'h0,
                      $urandom_range(0, 2), ld_tab[i].rdata);
            chk("tab_load", load_data_out, ld_tab[i].exp);
        end
        idle_cycle();

        for (int i = 0; i < 4; i++) begin
            wr_cycles = 0;
            do_access(1'b0, 1'b1, st_tab[i].f3, st_tab[i].addr, st_tab[i].sd, 0, 32'h0);
            chk("tab_st_addr", obs_addr, st_tab[i].exp_addr);
            chk("tab_st_be", obs_be, st_tab[i].exp_be);
            chk("tab_st_wdata", obs_wdata, st_tab[i].exp_wd);
            chk("tab_st_wrcyc", wr_cycles, 1);
            chk("tab_st_load_hold", load_data_out, ld_tab[9].exp);
        end
        idle_cycle();

        // LW then SB back-to-back, immediate ready
        busy_hist = 0; rd_cycles = 0; wr_cycles = 0;
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h0BADF00D);
        do_access(1'b0, 1'b1, 3'b000, 32'h43, 32'hA5, 0, 32'h0);
        chk("b2b_busy", busy_hist[5:0], 6'b110110);
        chk("b2b_rdcyc", rd_cycles, 1);
        chk("b2b_wrcyc", wr_cycles, 1);
        chk("b2b_load", load_data_out, 32'h0BADF00D);

        // Read and write together: write wins
        rd_cycles = 0; wr_cycles = 0;
        do_access(1'b1, 1'b1, 3'b010, 32'h80, 32'h11223344, 1, 32'hFFFFFFFF);
        chk("both_rdcyc", rd_cycles, 0);
        chk("both_load_hold", load_data_out, 32'h0BADF00D);
        idle_cycle();

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        rd_cycles = 0;
        do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h12345678);
        chk("mis_rdcyc", rd_cycles, 0);
        chk("mis_load_hold", load_data_out, 32'h0BADF00D);
        @(negedge clk);
        #1;
        chk("mis_fault_one_cycle", misalign_fault, 0);
        idle_cycle();
`endif

        for (int n = 0; n < 80; n++) begin
            int          kind;
            logic        rd, wr;
            logic [2:0]  f3;
            kind = $urandom_range(0, 9);
            rd   = (kind <= 4) || (kind == 9);
            wr   = (kind >= 5);
            f3   = rd && !wr ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            do_access(rd, wr, f3, $urandom, $urandom, $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
